// File: rtl/aq_fifo_wr_packer.sv
// aq_fifo_wr_packer: producer-side write front end for the async FIFO.
// Holds one word back so that any commit can carry FIFO_WR_LAST.
module aq_fifo_wr_packer #(
    parameter int FIFO_WIDTH   = 64,
    parameter int BURST_LEN    = 16,
    parameter int IDLE_TIMEOUT = 32
) (
    input  logic                  RST_N,
    input  logic                  FIFO_WR_CLK,
    input  logic                  S_VALID,
    output logic                  S_READY,
    input  logic [FIFO_WIDTH-1:0] S_DATA,
    input  logic                  S_LAST,
    input  logic                  FLUSH,
    output logic                  FIFO_WR_ENA,
    output logic [FIFO_WIDTH-1:0] FIFO_WR_DATA,
    output logic                  FIFO_WR_LAST,
    input  logic                  FIFO_WR_FULL,
    input  logic                  FIFO_WR_ALM_FULL,
    output logic                  BUSY,
    output logic [15:0]           COMMIT_CNT
);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [FIFO_WIDTH-1:0]   hold_data_q, hold_data_d;
    logic                    hold_last_q, hold_last_d;
    logic [BW-1:0]           burst_q, burst_d;
    logic [IW-1:0]           idle_q, idle_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    accept;
    logic                    commit_cond;

    always_comb begin
        S_READY = 1'b0;
        unique case (state_q)
            ST_EMPTY: S_READY = ~FIFO_WR_ALM_FULL;
            ST_HOLD:  S_READY = ~FIFO_WR_FULL & ~FIFO_WR_ALM_FULL;
            default:  S_READY = 1'b0;
        endcase
    end

    assign accept      = S_VALID & S_READY;
    assign commit_cond = hold_last_q | (burst_q == BURST_MAX)
                       | (idle_q == IDLE_MAX) | FLUSH | FIFO_WR_ALM_FULL;

    assign FIFO_WR_DATA = hold_data_q;
    assign BUSY         = (state_q != ST_EMPTY);
    assign COMMIT_CNT   = cnt_q;

    always_comb begin
        state_d      = state_q;
        hold_data_d  = hold_data_q;
        hold_last_d  = hold_last_q;
        burst_d      = burst_q;
        idle_d       = idle_q;
        cnt_d        = cnt_q;
        FIFO_WR_ENA  = 1'b0;
        FIFO_WR_LAST = 1'b0;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    hold_data_d = S_DATA;
                    hold_last_d = S_LAST;
                    idle_d      = '0;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (commit_cond && !FIFO_WR_FULL) begin
                    FIFO_WR_ENA  = 1'b1;
                    FIFO_WR_LAST = 1'b1;
                    idle_d       = '0;
                    if (accept) begin
                        hold_data_d = S_DATA;
                        hold_last_d = S_LAST;
                    end else begin
                        hold_last_d = 1'b0;
                        state_d     = ST_EMPTY;
                    end
                end else if (commit_cond) begin
                    idle_d  = '0;
                    state_d = ST_COMMIT;
                end else if (accept) begin
                    FIFO_WR_ENA = 1'b1;
                    hold_data_d = S_DATA;
                    hold_last_d = S_LAST;
                    idle_d      = '0;
                end else if (idle_q != IDLE_MAX) begin
                    idle_d = idle_q + IW'(1);
                end
            end
            ST_COMMIT: begin
                if (!FIFO_WR_FULL) begin
                    FIFO_WR_ENA  = 1'b1;
                    FIFO_WR_LAST = 1'b1;
                    hold_last_d  = 1'b0;
                    state_d      = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Burst length counts writes since the last commit marker
        if (FIFO_WR_ENA) begin
            if (FIFO_WR_LAST) begin
                burst_d = '0;
                cnt_d   = cnt_q + 16'd1;
            end else begin
                burst_d = burst_q + BW'(1);
            end
        end
    end

    always_ff @(posedge FIFO_WR_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_EMPTY;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            burst_q     <= '0;
            idle_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            burst_q     <= burst_d;
            idle_q      <= idle_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_aq_fifo_wr_packer.sv
// tb_aq_fifo_wr_packer: directed scenarios plus a randomized stream
// checked against an ordered word scoreboard and commit bookkeeping.
module tb_aq_fifo_wr_packer;
    localparam int W  = 64;
    localparam int BL = 4;
    localparam int TO = 32;
    localparam int NW = 10000;

    logic          RST_N;
    logic          clk;
    logic          S_VALID;
    logic          S_READY;
    logic [W-1:0]  S_DATA;
    logic          S_LAST;
    logic          FLUSH;
    logic          FIFO_WR_ENA;
    logic [W-1:0]  FIFO_WR_DATA;
    logic          FIFO_WR_LAST;
    logic          FIFO_WR_FULL;
    logic          FIFO_WR_ALM_FULL;
    logic          BUSY;
    logic [15:0]   COMMIT_CNT;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] accq[$];
    logic [W:0]   wlog[$];
    int pending   = 0;
    int committed = 0;
    int accepted  = 0;
    int lasts     = 0;

    aq_fifo_wr_packer #(
        .FIFO_WIDTH  (W),
        .BURST_LEN   (BL),
        .IDLE_TIMEOUT(TO)
    ) dut (
        .RST_N           (RST_N),
        .FIFO_WR_CLK     (clk),
        .S_VALID         (S_VALID),
        .S_READY         (S_READY),
        .S_DATA          (S_DATA),
        .S_LAST          (S_LAST),
        .FLUSH           (FLUSH),
        .FIFO_WR_ENA     (FIFO_WR_ENA),
        .FIFO_WR_DATA    (FIFO_WR_DATA),
        .FIFO_WR_LAST    (FIFO_WR_LAST),
        .FIFO_WR_FULL    (FIFO_WR_FULL),
        .FIFO_WR_ALM_FULL(FIFO_WR_ALM_FULL),
        .BUSY            (BUSY),
        .COMMIT_CNT      (COMMIT_CNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W:0] obs,
                       input logic [W:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] d,
                        input logic l, input logic f,
                        input logic full, input logic alm);
        @(posedge clk);
        #1;
        S_VALID          = v;
        S_DATA           = d;
        S_LAST           = l;
        FLUSH            = f;
        FIFO_WR_FULL     = full;
        FIFO_WR_ALM_FULL = alm;
        @(negedge clk);
    endtask

    // FIFO-side monitor: every write must be the oldest accepted word
    always @(negedge clk) begin
        if (!RST_N) begin
            accq.delete();
            pending   = 0;
            committed = 0;
            accepted  = 0;
            lasts     = 0;
        end else begin
            if (S_VALID && S_READY) begin
                accq.push_back(S_DATA);
                accepted++;
            end
            if (FIFO_WR_ENA) begin
                logic [W-1:0] exp_d;
                exp_d = (accq.size() > 0) ? accq.pop_front() : 'x;
                wlog.push_back({FIFO_WR_LAST, FIFO_WR_DATA});
                chk("wr_order", {1'b0, FIFO_WR_DATA}, {1'b0, exp_d});
                chk("wr_while_full", FIFO_WR_FULL, 0);
                pending++;
                if (FIFO_WR_LAST) begin
                    chk("burst_len", pending <= BL, 1);
                    committed += pending;
                    pending = 0;
                    lasts++;
                end
            end
        end
    end

    initial begin
        logic full_s;
        logic alm_s;
        RST_N            = 1'b0;
        S_VALID          = 1'b0;
        S_DATA           = '0;
        S_LAST           = 1'b0;
        FLUSH            = 1'b0;
        FIFO_WR_FULL     = 1'b0;
        FIFO_WR_ALM_FULL = 1'b0;
        #1;
        chk("rst_busy", BUSY, 0);
        chk("rst_ena", FIFO_WR_ENA, 0);
        chk("rst_ready", S_READY, 1);
        chk("rst_cc", COMMIT_CNT, 0);
        #12 RST_N = 1'b1;

        // T1: back-to-back 0..9, bursts of 4, idle-timeout tail
        wlog.delete();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, W'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            chk("t1_ena", FIFO_WR_ENA, i > 0);
        end
        for (int k = 0; k < TO; k++) begin
            step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("t1_idle_ena", FIFO_WR_ENA, 0);
        end
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_to_ena", FIFO_WR_ENA, 1);
        chk("t1_to_last", FIFO_WR_LAST, 1);
        chk("t1_to_data", FIFO_WR_DATA, 9);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_busy", BUSY, 0);
        chk("t1_cc", COMMIT_CNT, 3);
        chk("t1_nlog", wlog.size(), 10);
        for (int i = 0; i < 10; i++) begin
            logic l;
            l = (i == 3) || (i == 7) || (i == 9);
            chk("t1_log", wlog[i], {l, W'(i)});
        end

        // T2: packet A,B,C with S_LAST on C
        step(1'b1, 'hA, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_a_ena", FIFO_WR_ENA, 0);
        step(1'b1, 'hB, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_wa", {FIFO_WR_ENA, FIFO_WR_LAST, FIFO_WR_DATA[7:0]}, 'h20A);
        step(1'b1, 'hC, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_wb", {FIFO_WR_ENA, FIFO_WR_LAST, FIFO_WR_DATA[7:0]}, 'h20B);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_wc", {FIFO_WR_ENA, FIFO_WR_LAST, FIFO_WR_DATA[7:0]}, 'h30C);
        chk("t2_busy_c", BUSY, 1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_busy_after", BUSY, 0);
        chk("t2_cc", COMMIT_CNT, 4);

        // T3: flush under FULL parks in COMMIT until FULL drops
        step(1'b1, 'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_ready0", S_READY, 1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t3_flush_ena", FIFO_WR_ENA, 0);
        chk("t3_flush_rdy", S_READY, 0);
        for (int k = 0; k < 19; k++) begin
            step(1'b1, 'h66, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("t3_full_ena", FIFO_WR_ENA, 0);
            chk("t3_full_rdy", S_READY, 0);
        end
        chk("t3_busy", BUSY, 1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_rel_rdy", S_READY, 0);
        chk("t3_wx", {FIFO_WR_ENA, FIFO_WR_LAST, FIFO_WR_DATA[7:0]}, 'h355);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_busy_after", BUSY, 0);
        chk("t3_rdy_after", S_READY, 1);
        chk("t3_cc", COMMIT_CNT, 5);

        // T4: almost-full mid-stream
        step(1'b1, 'hD0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 'hD1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 'hD2, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_wd1", {FIFO_WR_ENA, FIFO_WR_LAST, FIFO_WR_DATA[7:0]}, 'h2D1);
        step(1'b1, 'hD3, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_alm_rdy", S_READY, 0);
        chk("t4_wd2", {FIFO_WR_ENA, FIFO_WR_LAST, FIFO_WR_DATA[7:0]}, 'h3D2);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 'hD3, 1'b0, 1'b0, 1'b0, 1'b1);
            chk("t4_blk_rdy", S_READY, 0);
            chk("t4_blk_ena", FIFO_WR_ENA, 0);
        end
        step(1'b1, 'hD3, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_rel_rdy", S_READY, 1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_wd3", {FIFO_WR_ENA, FIFO_WR_LAST, FIFO_WR_DATA[7:0]}, 'h3D3);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_cc", COMMIT_CNT, 7);

        // T5: reset while holding a word mid-burst
        step(1'b1, 'h90, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 'h91, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 'h92, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        RST_N   = 1'b0;
        S_VALID = 1'b0;
        #1;
        chk("t5_busy", BUSY, 0);
        chk("t5_ena", FIFO_WR_ENA, 0);
        chk("t5_cc", COMMIT_CNT, 0);
        chk("t5_rdy", S_READY, 1);
        @(posedge clk);
        #1 RST_N = 1'b1;
        wlog.delete();
        for (int i = 0; i < 5; i++)
            step(1'b1, W'(256 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_nlog", wlog.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("t5_log", wlog[i], {(i >= 3), W'(256 + i)});
        chk("t5_cc_after", COMMIT_CNT, 2);

        // T6: random valid/full/alm_full/flush/last
        full_s = 1'b0;
        alm_s  = 1'b0;
        for (int c = 0; c < 60000 && accepted < NW; c++) begin
            if (full_s) full_s = ($urandom_range(3) != 0);
            else        full_s = ($urandom_range(19) == 0);
            if (alm_s)  alm_s  = ($urandom_range(4) != 0);
            else        alm_s  = ($urandom_range(29) == 0);
            step($urandom_range(9) < 7, {$urandom, $urandom},
                 $urandom_range(19) == 0, $urandom_range(31) == 0,
                 full_s, alm_s);
        end
        chk("t6_budget", accepted >= NW, 1);
        for (int k = 0; k < TO + 8; k++)
            step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_left", accq.size(), 0);
        chk("t6_committed", committed, accepted);
        chk("t6_pending", pending, 0);
        chk("t6_busy", BUSY, 0);
        chk("t6_cc", COMMIT_CNT, lasts & 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
